ctr_block_feeder: RTL and testbench

CTR_BLOCK_FEEDER -- requirements
Module: ctr_block_feeder

---
 rtl/ctr_pkg.sv | 25 ++
 rtl/ctr_counter_inc.sv | 21 ++
 rtl/ctr_block_feeder.sv | 131 +++++++++++++
 tb/tb_ctr_block_feeder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctr_pkg.sv
// Shared constants, state encoding and length clamp helper for the CTR block feeder.
package ctr_pkg;

  localparam int BLOCK_W      = 128;
  localparam int WORD_W       = 32;
  localparam int MAX_LEN_BITS = 2000;
  localparam int MAX_BLOCKS   = 16;
  localparam int LEN_W        = 11;
  localparam int NBITS_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Oversized lengths are cut down to the largest message we can carry.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input int max_len);
    if (int'(len) > max_len) return LEN_W'(max_len);
    return len;
  endfunction

endpackage

// File: rtl/ctr_counter_inc.sv
// Counter-block increment for CTR mode.
// Build option CTR_INC32_EN: only the low 32 bits wrap-increment, upper 96 bits pass through.
// Default: full 128-bit increment modulo 2^128.
module ctr_counter_inc (
  input  logic [127:0] ctr_in,
  output logic [127:0] ctr_out
);

`ifdef CTR_INC32_EN
  // Low word increments with wrap; upper bits stay as loaded from iv.
  always_comb begin
    ctr_out = {ctr_in[127:32], ctr_in[31:0] + 32'd1};
  end
`else
  // Full-width increment with carry across all 128 bits.
  always_comb begin
    ctr_out = ctr_in + 128'd1;
  end
`endif

endmodule

// File: rtl/ctr_block_feeder.sv
// Packs a plaintext word stream into 128-bit blocks, each paired with its counter block.
// Build option CTR_INC32_EN (in ctr_counter_inc) selects 32-bit counter increment.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; iv/length latched on start
// FILL    | accepting words into the current block (in_ready high)
// EMIT    | block presented on out_*; waits for out_ready
// DONE    | one-cycle done pulse, then back to IDLE
module ctr_block_feeder #(
  parameter int WORD_W       = ctr_pkg::WORD_W,
  parameter int MAX_LEN_BITS = ctr_pkg::MAX_LEN_BITS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [127:0]  iv,
  input  logic [10:0]   length,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_block,
  output logic [127:0]  out_ctr,
  output logic [7:0]    out_nbits,
  output logic          out_last,
  output logic          busy,
  output logic          done
);
  import ctr_pkg::*;

  localparam int WPB   = BLOCK_W / WORD_W;
  localparam int IDX_W = (WPB > 1) ? $clog2(WPB) : 1;

  state_t               state, state_nxt;
  logic [BLOCK_W-1:0]   blk;
  logic [BLOCK_W-1:0]   ctr;
  logic [BLOCK_W-1:0]   ctr_inc;
  logic [LEN_W-1:0]     in_rem;   // message bits not yet delivered as words
  logic [LEN_W-1:0]     blk_rem;  // message bits not yet emitted as blocks
  logic [IDX_W-1:0]     widx;
  logic [WORD_W-1:0]    word_mask;
  logic                 accept;
  logic                 last_word;
  logic                 blk_full;
  logic                 blk_last;
  logic                 emit_hs;

  ctr_counter_inc u_ctr_inc (
    .ctr_in  (ctr),
    .ctr_out (ctr_inc)
  );

  assign accept    = (state == ST_FILL) && in_valid;
  assign emit_hs   = (state == ST_EMIT) && out_ready;
  assign last_word = (in_rem <= LEN_W'(WORD_W));
  assign blk_full  = (widx == IDX_W'(WPB - 1));
  assign blk_last  = (blk_rem <= LEN_W'(BLOCK_W));

  // Keep only the leading in_rem bits of a partial final word.
  always_comb begin
    word_mask = '1;
    if (in_rem < LEN_W'(WORD_W)) word_mask = ~({WORD_W{1'b1}} >> in_rem);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start) state_nxt = (length == '0) ? ST_DONE : ST_FILL;
      ST_FILL: if (accept && (blk_full || last_word)) state_nxt = ST_EMIT;
      ST_EMIT: if (out_ready) state_nxt = blk_last ? ST_DONE : ST_FILL;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from state and datapath registers.
  always_comb begin
    in_ready  = (state == ST_FILL);
    out_valid = (state == ST_EMIT);
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    out_last  = (state == ST_EMIT) && blk_last;
    out_nbits = '0;
    if (state == ST_EMIT) out_nbits = (blk_rem >= LEN_W'(BLOCK_W)) ? 8'd128 : blk_rem[7:0];
  end

  assign out_block = blk;
  assign out_ctr   = ctr;

  // Datapath: latch message parameters, pack words, advance counter per block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk     <= '0;
      ctr     <= '0;
      in_rem  <= '0;
      blk_rem <= '0;
      widx    <= '0;
    end else begin
      if ((state == ST_IDLE) && start) begin
        blk     <= '0;
        ctr     <= iv;
        in_rem  <= clamp_len(length, MAX_LEN_BITS);
        blk_rem <= clamp_len(length, MAX_LEN_BITS);
        widx    <= '0;
      end
      if (accept) begin
        for (int i = 0; i < WPB; i++) begin
          if (widx == IDX_W'(i)) blk[BLOCK_W-1-i*WORD_W -: WORD_W] <= in_data & word_mask;
        end
        widx   <= widx + 1'b1;
        in_rem <= last_word ? '0 : in_rem - LEN_W'(WORD_W);
      end
      if (emit_hs) begin
        blk     <= '0;
        widx    <= '0;
        ctr     <= ctr_inc;
        blk_rem <= blk_last ? '0 : blk_rem - LEN_W'(BLOCK_W);
      end
    end
  end

endmodule

// File: tb/tb_ctr_block_feeder.sv
// Directed bench for ctr_block_feeder with a bit-level reference model of the message.
module tb_ctr_block_feeder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] iv = '0;
  logic [10:0]  length = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_block;
  logic [127:0] out_ctr;
  logic [7:0]   out_nbits;
  logic         out_last;
  logic         busy;
  logic         done;

  ctr_block_feeder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .iv(iv), .length(length),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .out_ctr(out_ctr), .out_nbits(out_nbits), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_cyc = -100;
  int st_cyc = -100;
  logic saw_in_ready = 1'b0;
  logic saw_out_valid = 1'b0;

  logic [31:0]  wbuf[$];
  logic [127:0] q_blk[$], q_ctr[$];
  logic [7:0]   q_nb[$];
  logic         q_last[$];
  logic [127:0] got_blk[$], got_ctr[$];
  logic [7:0]   got_nb[$];

  logic         prev_hold = 1'b0;
  logic [127:0] prev_blk, prev_ctr;
  logic [7:0]   prev_nb;
  logic         prev_last;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out at cycle %0d", name, cyc);
  endtask

  // Reference: block n holds message bits 128n..128n+127, MSB first, zero past length.
  function automatic void model_msg(input logic [127:0] v, input int len);
    int l, nblk, g, nb;
    logic [127:0] b, c;
    logic [31:0] w;
    l = (len > 2000) ? 2000 : len;
    nblk = (l + 127) / 128;
    for (int n = 0; n < nblk; n++) begin
      b = '0;
      for (int j = 0; j < 128; j++) begin
        g = 128 * n + j;
        if (g < l) begin
          w = wbuf[g / 32];
          b[127 - j] = w[31 - (g % 32)];
        end
      end
`ifdef CTR_INC32_EN
      c = {v[127:32], v[31:0] + 32'(n)};
`else
      c = v + 128'(n);
`endif
      nb = (l - 128 * n >= 128) ? 128 : l - 128 * n;
      q_blk.push_back(b);
      q_ctr.push_back(c);
      q_nb.push_back(8'(nb));
      q_last.push_back(n == nblk - 1);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: every handshake against the model, holds for stability, EMIT excludes FILL.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold <= 1'b0;
    end else begin
      if (in_ready) saw_in_ready = 1'b1;
      if (out_valid) saw_out_valid = 1'b1;
      if (out_valid && in_ready) chk("ready_overlap", 1, 0);
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_block", out_block, prev_blk);
        chk("hold_ctr", out_ctr, prev_ctr);
        chk("hold_nbits", out_nbits, prev_nb);
        chk("hold_last", out_last, prev_last);
      end
      prev_hold <= out_valid && !out_ready;
      prev_blk  <= out_block;
      prev_ctr  <= out_ctr;
      prev_nb   <= out_nbits;
      prev_last <= out_last;
      if (out_valid && out_ready) begin
        hs_cyc = cyc;
        got_blk.push_back(out_block);
        got_ctr.push_back(out_ctr);
        got_nb.push_back(out_nbits);
        if (q_blk.size() == 0) begin
          chk("unexpected_block", 1, 0);
        end else begin
          chk("blk", out_block, q_blk.pop_front());
          chk("ctr", out_ctr, q_ctr.pop_front());
          chk("nbits", out_nbits, q_nb.pop_front());
          chk("last", out_last, q_last.pop_front());
        end
      end
    end
  end

  task automatic clear_logs();
    got_blk.delete(); got_ctr.delete(); got_nb.delete();
    saw_in_ready = 1'b0; saw_out_valid = 1'b0;
  endtask

  task automatic do_start(input logic [127:0] v, input logic [10:0] len);
    @(posedge clk); #1;
    iv = v; length = len; start = 1'b1;
    @(negedge clk); st_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_words(input int n);
    int k;
    for (int i = 0; i < n; i++) begin
      in_data = wbuf[i];
      in_valid = 1'b1;
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 300) begin @(negedge clk); k++; end
      if (k >= 300) begin timeout("word_accept"); in_valid = 1'b0; return; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int exp_cyc);
    int k = 0;
    @(negedge clk);
    while (!done && k < 300) begin @(negedge clk); k++; end
    if (k >= 300) begin timeout("done"); return; end
    chk("done_cycle", 128'(cyc), 128'(exp_cyc < 0 ? hs_cyc + 1 : exp_cyc));
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    chk("model_drained", 128'(q_blk.size()), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_block"}, out_block, 0);
    chk({tag, "_out_ctr"}, out_ctr, 0);
    chk({tag, "_out_nbits"}, out_nbits, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // One full block.
    clear_logs();
    wbuf = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    model_msg(128'd0, 128);
    do_start(128'd0, 11'd128);
    send_words(4);
    wait_done(-1);
    chk("t1_nblocks", 128'(got_blk.size()), 1);
    if (got_blk.size() == 1) begin
      chk("t1_block_lit", got_blk[0], 128'h00112233_44556677_8899AABB_CCDDEEFF);
      chk("t1_ctr_lit", got_ctr[0], 128'd0);
      chk("t1_nbits_lit", got_nb[0], 128);
    end

    // Two blocks, partial tail.
    clear_logs();
    wbuf = '{7{32'hFFFFFFFF}};
    model_msg(128'd5, 200);
    do_start(128'd5, 11'd200);
    send_words(7);
    wait_done(-1);
    chk("t2_nblocks", 128'(got_blk.size()), 2);
    if (got_blk.size() == 2) begin
      chk("t2_b0_lit", got_blk[0], {128{1'b1}});
      chk("t2_b1_lit", got_blk[1], 128'hFFFFFFFF_FFFFFFFF_FF000000_00000000);
      chk("t2_c1_lit", got_ctr[1], 128'd6);
      chk("t2_nb1_lit", got_nb[1], 72);
    end

    // Zero length.
    clear_logs();
    do_start(128'h1234, 11'd0);
    wait_done(st_cyc + 1);
    chk("t3_no_in_ready", saw_in_ready, 0);
    chk("t3_no_out_valid", saw_out_valid, 0);

    // Counter carry across bit 32 / bit 64.
    clear_logs();
    wbuf = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7};
    model_msg(128'h0_FFFFFFFF_FFFFFFFF, 256);
    do_start(128'h0_FFFFFFFF_FFFFFFFF, 11'd256);
    send_words(8);
    wait_done(-1);
    if (got_ctr.size() == 2) begin
`ifdef CTR_INC32_EN
      chk("t4_ctr1_lit", got_ctr[1], 128'h00000000_00000000_FFFFFFFF_00000000);
`else
      chk("t4_ctr1_lit", got_ctr[1], 128'h00000000_00000001_00000000_00000000);
`endif
    end else chk("t4_nblocks", 128'(got_ctr.size()), 2);

    // Backpressure in EMIT plus an ignored start while busy.
    clear_logs();
    wbuf = '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3, 32'hD4D4D4D4, 32'hE5E5E5E5};
    model_msg(128'd100, 160);
    @(posedge clk); #1 out_ready = 1'b0;
    do_start(128'd100, 11'd160);
    fork
      send_words(5);
      begin
        k = 0;
        while (!out_valid && k < 300) begin @(negedge clk); k++; end
        if (k >= 300) timeout("t5_emit");
        @(posedge clk); #1;
        iv = 128'hDEAD; length = 11'd32; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("t5_in_ready_low", in_ready, 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    wait_done(-1);
    chk("t5_nblocks", 128'(got_blk.size()), 2);

    // Length above the maximum is clamped.
    clear_logs();
    wbuf.delete();
    for (int i = 0; i < 63; i++) wbuf.push_back($urandom);
    model_msg(128'd7, 2047);
    do_start(128'd7, 11'd2047);
    send_words(63);
    wait_done(-1);
    chk("t6_nblocks", 128'(got_blk.size()), 16);
    if (got_nb.size() == 16) chk("t6_last_nbits", got_nb[15], 80);

    // Reset in the middle of a message.
    clear_logs();
    wbuf = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    do_start(128'd9, 11'd128);
    send_words(2);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    @(posedge clk); #1 rst_n = 1'b1;
    wbuf = '{32'hA5A50F0F};
    model_msg(128'h77, 32);
    do_start(128'h77, 11'd32);
    send_words(1);
    wait_done(-1);
    chk("t7_nblocks", 128'(got_blk.size()), 1);
    if (got_blk.size() == 1) begin
      chk("t7_block_lit", got_blk[0], 128'hA5A50F0F_00000000_00000000_00000000);
      chk("t7_ctr_lit", got_ctr[0], 128'h77);
      chk("t7_nbits_lit", got_nb[0], 32);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
